// File: rtl/lin_rx_buffer_mem.sv
// lin_rx_buffer_mem
//   LIN receive buffer memory. One byte-enabled write port (frame assembler
//   side) and NUM_RD independent registered read ports (APB / DMA side).
//   A clear engine zeroes the whole array one word per cycle after reset
//   release and on clr_req. While it runs, writes are dropped and reads
//   return zero.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   wr_en     write request; wr_addr/wr_data/wr_be qualify it
//   wr_be     byte enables, bit k selects wr_data[8k+7:8k]
//   wr_err    one-cycle pulse: the previous cycle's write was dropped
//   rd_en     per-port read request
//   rd_addr   packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rd_data   packed registered read data, port i = [i*DATA_W +: DATA_W]
//   rd_valid  one-cycle pulse per port: rd_data for that port was updated
//   clr_req   request a full clear (honoured only when idle)
//   busy      clear engine running (registered)
module lin_rx_buffer_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic                     wr_err,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int BE_W = DATA_W / 8;
  // One extra bit so that DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [ADDR_W-1:0]         clr_cnt_r;
  logic [ADDR_W-1:0]         clr_cnt_s;
  logic                      busy_r;
  logic                      wr_err_r;
  logic                      wr_ok_s;
  logic                      wr_err_s;
  logic [NUM_RD*DATA_W-1:0]  rd_data_r;
  logic [NUM_RD*DATA_W-1:0]  rd_data_s;
  logic [NUM_RD-1:0]         rd_valid_r;
  logic [NUM_RD-1:0]         rd_valid_s;
  logic [DATA_W-1:0]         mem_r [DEPTH];

  // Replace the enabled bytes of old_word with the matching bytes of new_word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // True when an address maps onto a physical word.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_C);
  endfunction

  // Write acceptance: idle, in range, and not colliding with a clear request
  // (the clear wins). Every other wr_en is reported as dropped.
  always_comb begin
    wr_ok_s  = 1'b0;
    wr_err_s = 1'b0;
    if (wr_en) begin
      wr_ok_s  = (state_r == ST_IDLE) && in_range(wr_addr) && !clr_req;
      wr_err_s = !wr_ok_s;
    end else begin
      wr_ok_s  = 1'b0;
      wr_err_s = 1'b0;
    end
  end

  // Clear engine next state: sweep 0..DEPTH-1, then idle until clr_req.
  always_comb begin
    state_s   = state_r;
    clr_cnt_s = clr_cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_C) begin
          state_s   = ST_IDLE;
          clr_cnt_s = {ADDR_W{1'b0}};
        end else begin
          clr_cnt_s = clr_cnt_r + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_s   = ST_CLEAR;
          clr_cnt_s = {ADDR_W{1'b0}};
        end else begin
          state_s   = ST_IDLE;
        end
      end
      default: begin
        state_s   = ST_CLEAR;
        clr_cnt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Read ports: zero while clearing or out of range, otherwise the stored
  // word with a same-cycle accepted write forwarded in (write-first).
  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra         = {ADDR_W{1'b0}};
    rd_data_s  = rd_data_r;
    rd_valid_s = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      if (rd_en[i]) begin
        rd_valid_s[i] = 1'b1;
        if ((state_r == ST_CLEAR) || !in_range(ra)) begin
          rd_data_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        end else if (wr_ok_s && (wr_addr == ra)) begin
          rd_data_s[i*DATA_W +: DATA_W] = merge_bytes(mem_r[ra], wr_data, wr_be);
        end else begin
          rd_data_s[i*DATA_W +: DATA_W] = mem_r[ra];
        end
      end else begin
        rd_valid_s[i] = 1'b0;
      end
    end
  end

  // Control and output registers; busy is registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_CLEAR;
      clr_cnt_r  <= {ADDR_W{1'b0}};
      busy_r     <= 1'b1;
      wr_err_r   <= 1'b0;
      rd_data_r  <= {(NUM_RD*DATA_W){1'b0}};
      rd_valid_r <= {NUM_RD{1'b0}};
    end else begin
      state_r    <= state_s;
      clr_cnt_r  <= clr_cnt_s;
      busy_r     <= (state_s == ST_CLEAR);
      wr_err_r   <= wr_err_s;
      rd_data_r  <= rd_data_s;
      rd_valid_r <= rd_valid_s;
    end
  end

  // Storage array: not reset; the clear engine zeroes it word by word.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[wr_addr] <= merge_bytes(mem_r[wr_addr], wr_data, wr_be);
    end
  end

  assign wr_err   = wr_err_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_lin_rx_buffer_mem.sv
// Bench for lin_rx_buffer_mem: two instances (DEPTH 16 and DEPTH 12) share
// one stimulus stream; a per-instance reference model tracks the array
// contents, the remaining clear cycles and the expected registered outputs.
module tb_lin_rx_buffer_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        wr_en_s;
  logic [3:0]  wr_addr_s;
  logic [31:0] wr_data_s;
  logic [3:0]  wr_be_s;
  logic [1:0]  rd_en_s;
  logic [7:0]  rd_addr_s;
  logic        clr_req_s;

  logic        wr_err   [2];
  logic [63:0] rd_data  [2];
  logic [1:0]  rd_valid [2];
  logic        busy     [2];

  lin_rx_buffer_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .NUM_RD(2)) u_dut16 (
    .clk(clk), .reset(reset), .wr_en(wr_en_s), .wr_addr(wr_addr_s),
    .wr_data(wr_data_s), .wr_be(wr_be_s), .wr_err(wr_err[0]), .rd_en(rd_en_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .clr_req(clr_req_s), .busy(busy[0])
  );

  lin_rx_buffer_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .NUM_RD(2)) u_dut12 (
    .clk(clk), .reset(reset), .wr_en(wr_en_s), .wr_addr(wr_addr_s),
    .wr_data(wr_data_s), .wr_be(wr_be_s), .wr_err(wr_err[1]), .rd_en(rd_en_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .clr_req(clr_req_s), .busy(busy[1])
  );

  // Reference model state
  int          depth_m [2];
  logic [31:0] mem_m   [2][16];
  int          remain_m[2];
  logic [31:0] exp_rd  [2][2];
  logic [1:0]  exp_rv  [2];
  logic        exp_err [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) w[b*8 +: 8] = new_w[b*8 +: 8];
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      remain_m[k] = depth_m[k];
      exp_err[k]  = 1'b0;
      exp_rv[k]   = 2'b00;
      for (int p = 0; p < 2; p++) exp_rd[k][p] = 32'h0;
      for (int a = 0; a < 16; a++) mem_m[k][a] = 32'h0;
    end
  endtask

  // Apply the buffer's rules for one rising edge using the current inputs.
  task automatic model_edge();
    logic busy_now, acc;
    logic [3:0] ra;
    for (int k = 0; k < 2; k++) begin
      busy_now   = (remain_m[k] > 0);
      acc        = wr_en_s && !busy_now && (int'(wr_addr_s) < depth_m[k]) && !clr_req_s;
      exp_err[k] = wr_en_s && !acc;
      for (int p = 0; p < 2; p++) begin
        ra = rd_addr_s[p*4 +: 4];
        if (rd_en_s[p]) begin
          exp_rv[k][p] = 1'b1;
          if (busy_now || int'(ra) >= depth_m[k]) exp_rd[k][p] = 32'h0;
          else if (acc && wr_addr_s == ra)
            exp_rd[k][p] = apply_be(mem_m[k][ra], wr_data_s, wr_be_s);
          else exp_rd[k][p] = mem_m[k][ra];
        end else begin
          exp_rv[k][p] = 1'b0;
        end
      end
      if (acc) mem_m[k][wr_addr_s] = apply_be(mem_m[k][wr_addr_s], wr_data_s, wr_be_s);
      if (busy_now) remain_m[k] = remain_m[k] - 1;
      else if (clr_req_s) begin
        remain_m[k] = depth_m[k];
        for (int a = 0; a < 16; a++) mem_m[k][a] = 32'h0;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("%s d%0d rd_valid%0d", ctx, k, p), 64'(rd_valid[k][p]), 64'(exp_rv[k][p]));
        check($sformatf("%s d%0d rd_data%0d", ctx, k, p), 64'(rd_data[k][p*32 +: 32]), 64'(exp_rd[k][p]));
      end
      check($sformatf("%s d%0d wr_err", ctx, k), 64'(wr_err[k]), 64'(exp_err[k]));
      check($sformatf("%s d%0d busy", ctx, k), 64'(busy[k]), 64'(remain_m[k] > 0));
    end
  endtask

  task automatic idle();
    wr_en_s = 1'b0; wr_addr_s = 4'd0; wr_data_s = 32'h0; wr_be_s = 4'h0;
    rd_en_s = 2'b00; rd_addr_s = 8'h00; clr_req_s = 1'b0;
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
    idle();
  endtask

  // Assert reset away from an edge, check async response, release on negedge.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en_s = 1'b1; wr_addr_s = a; wr_data_s = d; wr_be_s = be;
  endtask

  task automatic read_all(input string ctx);
    for (int a = 0; a < 16; a++) begin
      rd_en_s   = 2'b11;
      rd_addr_s = {4'(15 - a), 4'(a)};
      step(ctx);
    end
  endtask

  int cnt[2];

  initial begin
    depth_m[0] = 16;
    depth_m[1] = 12;
    idle();
    #1;
    do_reset();

    // 1: clear after reset, write while busy, everything reads 0
    wr(4'd1, 32'hCAFE_F00D, 4'hF);
    step("t1_busy_wr");
    check("t1 wr_err d16", 64'(wr_err[0]), 64'd1);
    repeat (15) step("t1_clear");
    check("t1 idle d16", 64'(busy[0]), 64'd0);
    read_all("t1_read");

    // 2: full write then partial byte-enable write, read back on port 0
    wr(4'd3, 32'hA5A5_A5A5, 4'hF);
    step("t2_w1");
    wr(4'd3, 32'h1234_5678, 4'b0101);
    step("t2_w2");
    rd_en_s = 2'b01; rd_addr_s = 8'h03;
    step("t2_rd");
    check("t2 merged d16", 64'(rd_data[0][31:0]), 64'h0000_0000_A534_A578);
    check("t2 valid d16", 64'(rd_valid[0][0]), 64'd1);
    step("t2_hold");

    // 3: write-first forwarding on port 1, port 0 on a neighbour address
    wr(4'd6, 32'h0BAD_0666, 4'hF);
    step("t3_pre");
    wr(4'd7, 32'hDEAD_BEEF, 4'hF);
    rd_en_s = 2'b11; rd_addr_s = {4'd7, 4'd6};
    step("t3_fwd");
    check("t3 fwd d16", 64'(rd_data[0][63:32]), 64'h0000_0000_DEAD_BEEF);
    check("t3 port0 d16", 64'(rd_data[0][31:0]), 64'h0000_0000_0BAD_0666);

    // 4: out-of-range write and read on the DEPTH 12 instance
    wr(4'd13, 32'h1313_1313, 4'hF);
    step("t4_wr");
    check("t4 wr_err d12", 64'(wr_err[1]), 64'd1);
    rd_en_s = 2'b11; rd_addr_s = 8'hDD;
    step("t4_rd");
    check("t4 oor data d12", rd_data[1], 64'h0);
    check("t4 oor valid d12", 64'(rd_valid[1]), 64'd3);
    wr(4'd2, 32'h1111_2222, 4'hF);
    step("t4_ok");
    check("t4 wr_be0 ok", 64'(wr_err[1]), 64'd0);

    // 5: clear request collides with a write; second request mid-clear
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin wr(4'd2, 32'h5555_5555, 4'hF); clr_req_s = 1'b1; end
      if (i == 5) clr_req_s = 1'b1;
      step("t5_clear");
      if (i == 0) check("t5 wr_err d12", 64'(wr_err[1]), 64'd1);
      for (int k = 0; k < 2; k++) if (busy[k]) cnt[k]++;
    end
    check("t5 busy len d12", 64'(cnt[1]), 64'd12);
    check("t5 busy len d16", 64'(cnt[0]), 64'd16);
    read_all("t5_read");

    // 6: reset in the middle of a clear; full clear after release
    wr(4'd4, 32'h4444_4444, 4'hF);
    step("t6_load");
    clr_req_s = 1'b1;
    step("t6_req");
    repeat (4) step("t6_mid");
    do_reset();
    for (int k = 0; k < 2; k++) cnt[k] = busy[k] ? 1 : 0;
    repeat (20) begin
      step("t6_clear");
      for (int k = 0; k < 2; k++) if (busy[k]) cnt[k]++;
    end
    check("t6 busy len d16", 64'(cnt[0]), 64'd16);
    check("t6 busy len d12", 64'(cnt[1]), 64'd12);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      wr_en_s   = 1'($urandom_range(0, 1));
      wr_addr_s = 4'($urandom_range(0, 15));
      wr_data_s = $urandom;
      wr_be_s   = 4'($urandom_range(0, 15));
      rd_en_s   = 2'($urandom_range(0, 3));
      rd_addr_s = ($urandom_range(0, 3) == 0) ? {wr_addr_s, wr_addr_s} : 8'($urandom_range(0, 255));
      clr_req_s = ($urandom_range(0, 59) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
